network_interface_tx: RTL and testbench

NETWORK_INTERFACE_TX -- requirements
Module: network_interface_tx

---
 rtl/network_interface_tx.sv | 149 ++++++++++++++
 tb/tb_network_interface_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_interface_tx.sv
// network_interface_tx: packetises payload words into head/body/tail flits for one router
// input port. Each packet is one head flit (destination and source node IDs), FlitPerPacket-2
// body flits and one tail flit. The output stage is a single register with valid/ready flow
// control; a flit can be loaded in the same cycle the previous one is taken, so a stream with
// inputs always valid and ready_out held high gets one flit per cycle, tail-to-head included.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   pkt_valid/pkt_dest/pkt_ready packet request (destination node ID)
//   payload_in/_valid/_ready     payload words for body and tail flits
//   data_out/valid_out/ready_out flit stream to the router
//   pkt_count                    transferred tail flits, 16-bit wrapping
//                                (only when NI_TX_PKT_COUNT_EN is defined)
module network_interface_tx #(
  parameter int unsigned N             = 100,
  parameter int unsigned INDEX         = 1,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned FlitPerPacket = 6,
  localparam int unsigned DEST_WIDTH    = $clog2(N),
  localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pkt_valid,
  input  logic [DEST_WIDTH-1:0]    pkt_dest,
  output logic                     pkt_ready,
  input  logic [PAYLOAD_WIDTH-1:0] payload_in,
  input  logic                     payload_valid,
  output logic                     payload_ready,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
`ifdef NI_TX_PKT_COUNT_EN
  output logic [15:0]              pkt_count,
`endif
  input  logic                     ready_out
);

  localparam int unsigned CntWidth = $clog2(FlitPerPacket);
  // Count value seen on the last body handshake; unused when there are no body flits.
  localparam int unsigned LastBody = (FlitPerPacket > 2) ? FlitPerPacket - 3 : 0;

  localparam logic [TYPE_WIDTH-1:0] TypeHead = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TypeBody = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] TypeTail = TYPE_WIDTH'(3);

  typedef enum logic [1:0] {StIdle, StBody, StTail} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   body_cnt_q, body_cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  slot_free;
  logic [DATA_WIDTH-1:0] head_flit, pay_flit;
`ifdef NI_TX_PKT_COUNT_EN
  logic [15:0]           pkt_count_q, pkt_count_d;
`endif

  always_comb begin
    slot_free     = !valid_q || ready_out;
    state_d       = state_q;
    body_cnt_d    = body_cnt_q;
    // An accepted flit with nothing new behind it empties the register.
    valid_d       = valid_q && !ready_out;
    data_d        = data_q;
    pkt_ready     = 1'b0;
    payload_ready = 1'b0;

    head_flit = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]   = TypeHead;
    head_flit[DEST_WIDTH-1:0]               = pkt_dest;
    head_flit[2*DEST_WIDTH-1 -: DEST_WIDTH] = DEST_WIDTH'(INDEX);

    pay_flit = '0;
    pay_flit[PAYLOAD_WIDTH-1:0] = payload_in;

    // Handshakes are held off while reset is asserted.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          pkt_ready = slot_free;
          if (pkt_valid && slot_free) begin
            valid_d = 1'b1;
            data_d  = head_flit;
            state_d = (FlitPerPacket > 2) ? StBody : StTail;
          end
        end
        StBody: begin
          payload_ready = slot_free;
          if (payload_valid && slot_free) begin
            valid_d                             = 1'b1;
            data_d                              = pay_flit;
            data_d[DATA_WIDTH-1 -: TYPE_WIDTH]  = TypeBody;
            if (body_cnt_q == CntWidth'(LastBody)) begin
              body_cnt_d = '0;
              state_d    = StTail;
            end else begin
              body_cnt_d = body_cnt_q + 1'b1;
            end
          end
        end
        StTail: begin
          payload_ready = slot_free;
          if (payload_valid && slot_free) begin
            valid_d                             = 1'b1;
            data_d                              = pay_flit;
            data_d[DATA_WIDTH-1 -: TYPE_WIDTH]  = TypeTail;
            state_d                             = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

`ifdef NI_TX_PKT_COUNT_EN
    pkt_count_d = pkt_count_q;
    if (valid_q && ready_out && data_q[DATA_WIDTH-1 -: TYPE_WIDTH] == TypeTail) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      body_cnt_q  <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
`ifdef NI_TX_PKT_COUNT_EN
      pkt_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      body_cnt_q  <= body_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
`ifdef NI_TX_PKT_COUNT_EN
      pkt_count_q <= pkt_count_d;
`endif
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
`ifdef NI_TX_PKT_COUNT_EN
  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_network_interface_tx.sv
// Directed bench for network_interface_tx: a 6-flit instance (u_dut) and a 2-flit instance
// (u_min) share clock and reset. Checks pkt_count when NI_TX_PKT_COUNT_EN is defined.
module tb_network_interface_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid, pkt_ready, payload_valid, payload_ready, valid_out, ready_out;
  logic [6:0]  pkt_dest;
  logic [29:0] payload_in;
  logic [31:0] data_out;

  logic        m_pkt_valid, m_pkt_ready, m_payload_valid, m_payload_ready;
  logic        m_valid_out, m_ready_out;
  logic [6:0]  m_pkt_dest;
  logic [29:0] m_payload_in;
  logic [31:0] m_data_out;
`ifdef NI_TX_PKT_COUNT_EN
  logic [15:0] pkt_count, m_pkt_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int both_hi = 0;
  logic [31:0] obs[$];
  int          obs_cyc[$];
  logic [31:0] m_obs[$];
  logic [29:0] words[5];

  always #5 clk = ~clk;

  network_interface_tx #(.N(100), .INDEX(1), .DATA_WIDTH(32), .TYPE_WIDTH(2),
                         .FlitPerPacket(6)) u_dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_dest(pkt_dest), .pkt_ready(pkt_ready),
    .payload_in(payload_in), .payload_valid(payload_valid), .payload_ready(payload_ready),
    .data_out(data_out), .valid_out(valid_out),
`ifdef NI_TX_PKT_COUNT_EN
    .pkt_count(pkt_count),
`endif
    .ready_out(ready_out)
  );

  network_interface_tx #(.N(100), .INDEX(1), .DATA_WIDTH(32), .TYPE_WIDTH(2),
                         .FlitPerPacket(2)) u_min (
    .clk(clk), .rst(rst), .pkt_valid(m_pkt_valid), .pkt_dest(m_pkt_dest),
    .pkt_ready(m_pkt_ready), .payload_in(m_payload_in), .payload_valid(m_payload_valid),
    .payload_ready(m_payload_ready), .data_out(m_data_out), .valid_out(m_valid_out),
`ifdef NI_TX_PKT_COUNT_EN
    .pkt_count(m_pkt_count),
`endif
    .ready_out(m_ready_out)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded half a cycle before the edge that performs them.
  always @(negedge clk) begin
    if (valid_out && ready_out) begin
      obs.push_back(data_out);
      obs_cyc.push_back(cyc);
    end
    if (m_valid_out && m_ready_out) m_obs.push_back(m_data_out);
    if (pkt_ready && payload_ready) both_hi++;
  end

  task automatic drive_head(input logic [6:0] dest);
    bit done = 0;
    pkt_valid = 1'b1;
    pkt_dest  = dest;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (pkt_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    pkt_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL head_handshake timeout: pkt_ready=%b required 1", pkt_ready);
    end
  endtask

  task automatic drive_payloads(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      bit done = 0;
      payload_valid = 1'b1;
      payload_in    = words[first+k];
      for (int i = 0; i < 50 && !done; i++) begin
        @(negedge clk);
        if (payload_ready) begin
          @(posedge clk); #1;
          done = 1;
        end
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL payload_handshake timeout word %0d: payload_ready=%b required 1",
                 k, payload_ready);
      end
    end
    payload_valid = 1'b0;
  endtask

  task automatic drain;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!valid_out && !m_valid_out) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain timeout: valid_out=%b required 0", valid_out);
    end
  endtask

  task automatic set_words(input logic [29:0] a, b, c, d, e);
    words[0] = a; words[1] = b; words[2] = c; words[3] = d; words[4] = e;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pkt_valid = 0; payload_valid = 0; ready_out = 1; pkt_dest = '0; payload_in = '0;
    m_pkt_valid = 0; m_payload_valid = 0; m_ready_out = 1; m_pkt_dest = '0; m_payload_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (valid_out !== 1'b0) begin bad++;
      $display("FAIL reset_valid: got %b required 0", valid_out); end
    total++; if (data_out !== 32'h0) begin bad++;
      $display("FAIL reset_data: got %h required 00000000", data_out); end
    total++; if (pkt_ready !== 1'b0 || payload_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready: got %b%b required 00", pkt_ready, payload_ready); end
`ifdef NI_TX_PKT_COUNT_EN
    total++; if (pkt_count !== 16'h0) begin bad++;
      $display("FAIL reset_pkt_count: got %0d required 0", pkt_count); end
`endif
    rst = 1'b0;
    #1;
    total++; if (pkt_ready !== 1'b1 || payload_ready !== 1'b0) begin bad++;
      $display("FAIL post_reset_ready: got %b%b required 10", pkt_ready, payload_ready); end
    total++; if (m_pkt_ready !== 1'b1) begin bad++;
      $display("FAIL post_reset_min_ready: got %b required 1", m_pkt_ready); end
  endtask

  task automatic test_single_packet;
    int base = obs.size();
    logic [31:0] exp[6] = '{32'h40000085, 32'h800000AA, 32'h800000BB, 32'h800000CC,
                            32'h800000DD, 32'hC00000EE};
    set_words(30'hAA, 30'hBB, 30'hCC, 30'hDD, 30'hEE);
    drive_head(7'd5);
    drive_payloads(0, 5);
    drain();
    total++; if (obs.size() - base != 6) begin bad++;
      $display("FAIL single_count: got %0d flits required 6", obs.size() - base); end
    else for (int i = 0; i < 6; i++) begin
      total++; if (obs[base+i] !== exp[i]) begin bad++;
        $display("FAIL single_flit%0d: got %h required %h", i, obs[base+i], exp[i]); end
      total++; if (obs_cyc[base+i] != obs_cyc[base] + i) begin bad++;
        $display("FAIL single_cycle%0d: got %0d required %0d", i, obs_cyc[base+i],
                 obs_cyc[base] + i); end
    end
  endtask

  task automatic test_backpressure;
    int base = obs.size();
    logic [31:0] exp[6] = '{32'h40000085, 32'h800000AA, 32'h800000BB, 32'h800000CC,
                            32'h800000DD, 32'hC00000EE};
    set_words(30'hAA, 30'hBB, 30'hCC, 30'hDD, 30'hEE);
    ready_out = 1'b0;
    drive_head(7'd5);
    payload_valid = 1'b1;
    payload_in    = words[0];
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (valid_out !== 1'b1 || data_out !== 32'h40000085 || payload_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h pr=%b required v=1 d=40000085 pr=0",
                 i, valid_out, data_out, payload_ready);
      end
    end
    ready_out = 1'b1;
    drive_payloads(0, 5);
    drain();
    total++; if (obs.size() - base != 6) begin bad++;
      $display("FAIL bp_count: got %0d flits required 6", obs.size() - base); end
    else for (int i = 0; i < 6; i++) begin
      total++; if (obs[base+i] !== exp[i]) begin bad++;
        $display("FAIL bp_flit%0d: got %h required %h", i, obs[base+i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int base = obs.size();
    int bh0  = both_hi;
    logic [31:0] exp[12] = '{32'h40000085, 32'h800000AA, 32'h800000BB, 32'h800000CC,
                             32'h800000DD, 32'hC00000EE, 32'h40000089, 32'h80000011,
                             32'h80000022, 32'h80000033, 32'h80000044, 32'hC0000055};
    set_words(30'hAA, 30'hBB, 30'hCC, 30'hDD, 30'hEE);
    drive_head(7'd5);
    drive_payloads(0, 5);
    set_words(30'h11, 30'h22, 30'h33, 30'h44, 30'h55);
    drive_head(7'd9);
    drive_payloads(0, 5);
    drain();
    total++; if (obs.size() - base != 12) begin bad++;
      $display("FAIL b2b_count: got %0d flits required 12", obs.size() - base); end
    else for (int i = 0; i < 12; i++) begin
      total++; if (obs[base+i] !== exp[i]) begin bad++;
        $display("FAIL b2b_flit%0d: got %h required %h", i, obs[base+i], exp[i]); end
      total++; if (obs_cyc[base+i] != obs_cyc[base] + i) begin bad++;
        $display("FAIL b2b_cycle%0d: got %0d required %0d", i, obs_cyc[base+i],
                 obs_cyc[base] + i); end
    end
    total++; if (both_hi != bh0) begin bad++;
      $display("FAIL ready_exclusive: got %0d cycles with both high required 0",
               both_hi - bh0); end
  endtask

  task automatic test_reset_mid_packet;
    int base = obs.size();
    set_words(30'hAA, 30'hBB, 30'hCC, 30'hDD, 30'hEE);
    drive_head(7'd5);
    drive_payloads(0, 3);
    total++; if (obs.size() - base != 3) begin bad++;
      $display("FAIL mid_pre_count: got %0d flits required 3", obs.size() - base); end
    rst = 1'b1;
    #1;
    total++; if (valid_out !== 1'b0 || data_out !== 32'h0) begin bad++;
      $display("FAIL mid_reset_out: got v=%b d=%h required v=0 d=00000000",
               valid_out, data_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (pkt_ready !== 1'b1) begin bad++;
      $display("FAIL mid_release_ready: got %b required 1", pkt_ready); end
`ifdef NI_TX_PKT_COUNT_EN
    total++; if (pkt_count !== 16'h0) begin bad++;
      $display("FAIL mid_pkt_count: got %0d required 0", pkt_count); end
`endif
    drive_head(7'd5);
    drive_payloads(0, 5);
    drain();
    total++; if (obs.size() - base != 9) begin bad++;
      $display("FAIL mid_post_count: got %0d flits required 9", obs.size() - base); end
    else begin
      total++; if (obs[base+3] !== 32'h40000085) begin bad++;
        $display("FAIL mid_next_head: got %h required 40000085", obs[base+3]); end
      total++; if (obs[base+8] !== 32'hC00000EE) begin bad++;
        $display("FAIL mid_next_tail: got %h required c00000ee", obs[base+8]); end
    end
  endtask

  task automatic test_min_packet;
    int base = m_obs.size();
    logic [6:0]  dests[3] = '{7'd3, 7'd7, 7'd2};
    logic [29:0] pw[3]    = '{30'h101, 30'h202, 30'h303};
    logic [31:0] exp[6]   = '{32'h40000083, 32'hC0000101, 32'h40000087, 32'hC0000202,
                              32'h40000082, 32'hC0000303};
    for (int p = 0; p < 3; p++) begin
      bit done = 0;
      m_pkt_valid = 1'b1;
      m_pkt_dest  = dests[p];
      for (int i = 0; i < 50 && !done; i++) begin
        @(negedge clk);
        if (m_pkt_ready) begin @(posedge clk); #1; done = 1; end
      end
      m_pkt_valid     = 1'b0;
      m_payload_valid = 1'b1;
      m_payload_in    = pw[p];
      for (int i = 0; i < 50 && done; i++) begin
        @(negedge clk);
        if (m_payload_ready) begin @(posedge clk); #1; done = 0; end
      end
      m_payload_valid = 1'b0;
      if (done) begin
        total++; bad++;
        $display("FAIL min_handshake timeout packet %0d", p);
      end
    end
    drain();
    total++; if (m_obs.size() - base != 6) begin bad++;
      $display("FAIL min_count: got %0d flits required 6", m_obs.size() - base); end
    else for (int i = 0; i < 6; i++) begin
      total++; if (m_obs[base+i] !== exp[i]) begin bad++;
        $display("FAIL min_flit%0d: got %h required %h", i, m_obs[base+i], exp[i]); end
    end
`ifdef NI_TX_PKT_COUNT_EN
    total++; if (m_pkt_count !== 16'd3) begin bad++;
      $display("FAIL min_pkt_count: got %0d required 3", m_pkt_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_min_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
